// File: rtl/rv_exec_pkg.sv
// rv_exec shared constants: opcodes, funct fields and ALU op encoding.
// Optional retired-instruction counter is enabled with RV_EXEC_PERF_EN.
package rv_exec_pkg;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

endpackage

// File: rtl/rv_exec_alu.sv
// rv_exec ALU: purely combinational integer operations.
// Shift amount is 5 bits for XLEN=32 and 6 bits for XLEN=64.
module rv_exec_alu
  import rv_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [SHW-1:0] sh;

  assign sh = b[SHW-1:0];

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << sh;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> sh;
      ALU_SRA:  result = $unsigned($signed(a) >>> sh);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_exec_pipe.sv
// rv_exec_pipe: two-stage R/I-type ALU pipe with register file.
// Define RV_EXEC_PERF_EN to add the retired_count output.
module rv_exec_pipe
  import rv_exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal
`ifdef RV_EXEC_PERF_EN
  ,
  output logic [31:0]     retired_count
`endif
);

  localparam int IW = $clog2(NREGS);

  logic            s1_valid;
  logic [31:0]     s1_instr;
  logic            s2_valid;
  logic [4:0]      s2_rd;
  logic [XLEN-1:0] s2_data;
  logic            s2_illegal;
  logic [XLEN-1:0] regs [NREGS];

  logic            advance;
  logic            accept;
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  alu_op_e         op;
  logic            dec_ok;
  logic            use_imm;
  logic            idx_ok;
  logic            legal;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] res;

  assign opc = s1_instr[6:0];
  assign rd  = s1_instr[11:7];
  assign f3  = s1_instr[14:12];
  assign rs1 = s1_instr[19:15];
  assign rs2 = s1_instr[24:20];
  assign f7  = s1_instr[31:25];
  assign imm = {{(XLEN-12){s1_instr[31]}}, s1_instr[31:20]};

  always_comb begin
    op      = ALU_ADD;
    dec_ok  = 1'b0;
    use_imm = 1'b0;
    unique case (1'b1)
      opc == OP_REG && f7 == F7_BASE: begin
        dec_ok = 1'b1;
        unique case (f3)
          F3_ADD:  op = ALU_ADD;
          F3_SLL:  op = ALU_SLL;
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_SR:   op = ALU_SRL;
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
        endcase
      end
      opc == OP_REG && f7 == F7_ALT && f3 == F3_ADD: begin
        dec_ok = 1'b1;
        op     = ALU_SUB;
      end
      opc == OP_REG && f7 == F7_ALT && f3 == F3_SR: begin
        dec_ok = 1'b1;
        op     = ALU_SRA;
      end
      opc == OP_IMM && f3 == F3_ADD: begin
        dec_ok  = 1'b1;
        use_imm = 1'b1;
      end
      default: ;
    endcase
  end

  // rs2 field is immediate bits for ADDI, so it is only range-checked for R-type
  assign idx_ok = int'(rd) < NREGS && int'(rs1) < NREGS &&
                  (use_imm || int'(rs2) < NREGS);
  assign legal  = dec_ok && idx_ok;

  assign a       = (rs1 == 5'd0 || int'(rs1) >= NREGS) ? '0 : regs[rs1[IW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || int'(rs2) >= NREGS) ? '0 : regs[rs2[IW-1:0]];
  assign b       = use_imm ? imm : rs2_val;

  rv_exec_alu #(.XLEN(XLEN)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (res)
  );

  assign advance  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !reset && (!s1_valid || advance);
  assign accept   = in_valid && in_ready;

  // Writeback on the S1->S2 edge lets a dependent S1 entrant read the new value
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s2_valid   <= 1'b0;
      s2_rd      <= '0;
      s2_data    <= '0;
      s2_illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_instr <= instruction;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      if (advance) begin
        s2_valid   <= 1'b1;
        s2_rd      <= rd;
        s2_data    <= legal ? res : '0;
        s2_illegal <= !legal;
        if (legal && rd != 5'd0) regs[rd[IW-1:0]] <= res;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = !reset && s2_valid;
  assign out_rd      = reset ? '0 : s2_rd;
  assign out_data    = reset ? '0 : s2_data;
  assign out_illegal = !reset && s2_illegal;

`ifdef RV_EXEC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) retired_count <= '0;
    else if (out_valid && out_ready) retired_count <= retired_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rv_exec_pipe.sv
// Randomised and directed bench for rv_exec_pipe against a behavioural model.
// Exercises the RV_EXEC_PERF_EN counter when that macro is defined.
module tb_rv_exec_pipe;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  typedef struct packed {
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_illegal;

  logic        v16;
  logic        rdy16;
  logic [31:0] i16;
  logic        ov16;
  logic        ordy16 = 1'b1;
  logic [4:0]  rd16;
  logic [31:0] d16;
  logic        ill16;
`ifdef RV_EXEC_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] rc16;
`endif

  always #5 clk = ~clk;

  rv_exec_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .out_illegal (out_illegal)
`ifdef RV_EXEC_PERF_EN
    ,
    .retired_count (retired_count)
`endif
  );

  rv_exec_pipe #(.XLEN(32), .NREGS(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (v16),
    .in_ready    (rdy16),
    .instruction (i16),
    .out_valid   (ov16),
    .out_ready   (ordy16),
    .out_rd      (rd16),
    .out_data    (d16),
    .out_illegal (ill16)
`ifdef RV_EXEC_PERF_EN
    ,
    .retired_count (rc16)
`endif
  );

  int   passed = 0;
  int   total  = 0;
  int   hs_count = 0;
  bit   rand_rdy = 1'b0;
  res_t obs_q[$];
  res_t exp_q[$];
  logic [31:0] mregs [32];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_q.push_back('{out_rd, out_illegal, out_data});
      hs_count++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Architectural reference: executes in program order, updating mregs
  function automatic res_t predict(input logic [31:0] ins);
    logic [4:0]  rd  = ins[11:7];
    logic [31:0] a   = mregs[ins[19:15]];
    logic [31:0] b   = mregs[ins[24:20]];
    logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
    logic [9:0]  fn  = {ins[31:25], ins[14:12]};
    logic [31:0] r   = 0;
    bit          ok  = 1;
    if (ins[6:0] == OPI && ins[14:12] == 3'd0) r = a + imm;
    else if (ins[6:0] == OPR) begin
      case (fn)
        {7'h00, 3'd0}: r = a + b;
        {7'h20, 3'd0}: r = a - b;
        {7'h00, 3'd1}: r = a << b[4:0];
        {7'h00, 3'd2}: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: r = (a < b) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: r = a ^ b;
        {7'h00, 3'd5}: r = a >> b[4:0];
        {7'h20, 3'd5}: r = $signed(a) >>> b[4:0];
        {7'h00, 3'd6}: r = a | b;
        {7'h00, 3'd7}: r = a & b;
        default: ok = 0;
      endcase
    end else ok = 0;
    if (ok && rd != 0) mregs[rd] = r;
    return '{rd, !ok, ok ? r : 32'd0};
  endfunction

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k  = $urandom_range(0, 12);
    logic [31:0] w;
    if (k < 8) return rtype(7'h00, rreg(), rreg(), 3'(k), rreg());
    if (k == 8) return rtype(7'h20, rreg(), rreg(), 3'd0, rreg());
    if (k == 9) return rtype(7'h20, rreg(), rreg(), 3'd5, rreg());
    if (k < 12) return itype(12'($urandom), rreg(), 3'd0, rreg(), OPI);
    case ($urandom_range(0, 2))
      0: return itype(12'($urandom), rreg(), 3'($urandom_range(1, 7)), rreg(), OPI);
      1: return rtype(7'h01, rreg(), rreg(), 3'($urandom), rreg());
      default: begin
        w = $urandom();
        if (w[6:0] == OPR || w[6:0] == OPI) w[6:0] = OPL;
        return w;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    obs_q.delete();
    exp_q.delete();
    hs_count = 0;
  endtask

  // Offer one instruction; called and returns at posedge+1
  task automatic issue(input logic [31:0] ins);
    bit acc = 0;
    in_valid    = 1'b1;
    instruction = ins;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(predict(ins));
    else begin
      total++;
      $display("FAIL issue_timeout instr=%h accepted=0 required=1", ins);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && obs_q.size() < exp_q.size(); n++) @(posedge clk);
    @(posedge clk);
    #1;
    if (obs_q.size() != exp_q.size()) begin
      total++;
      $display("FAIL drain_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    instruction = itype(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    out_ready = 1'b1;
    v16 = 1'b0;
    i16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_rd !== 5'd0 ||
        out_data !== 32'd0 || out_illegal !== 1'b0)
      $display("FAIL reset_outputs got rdy=%b ov=%b rd=%0d d=%h ill=%b required all 0",
               in_ready, out_valid, out_rd, out_data, out_illegal);
    else passed++;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required=1", in_ready);
    else passed++;
`ifdef RV_EXEC_PERF_EN
    total++;
    if (retired_count !== 32'd0) $display("FAIL reset_count got=%0d required=0", retired_count);
    else passed++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    res_t r;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = itype(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_accept0 in_ready=%b required=1", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    r = predict(instruction);
    instruction = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_lat1 out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else passed++;
    @(posedge clk);
    #1;
    r = predict(instruction);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd5 || out_rd !== 5'd1)
      $display("FAIL b2b_first ov=%b d=%h rd=%0d required 1/5/1", out_valid, out_data, out_rd);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd10 || out_rd !== 5'd2)
      $display("FAIL b2b_second ov=%b d=%h rd=%0d required 1/a/2", out_valid, out_data, out_rd);
    else passed++;
    @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [31:0] ed [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd4, 32'hFFFFFFFF};
    logic [4:0]  er [6] = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8};
    issue(itype(12'hFFF, 5'd0, 3'd0, 5'd1, OPI));
    issue(rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd3));
    issue(rtype(7'h00, 5'd1, 5'd0, 3'd3, 5'd4));
    issue(rtype(7'h00, 5'd1, 5'd0, 3'd2, 5'd5));
    issue(itype(12'd4, 5'd0, 3'd0, 5'd7, OPI));
    issue(rtype(7'h20, 5'd7, 5'd1, 3'd5, 5'd8));
    drain();
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== ed[i] || obs_q[i].rd !== er[i] || obs_q[i].ill !== 1'b0)
        $display("FAIL wrap_%0d got rd=%0d d=%h ill=%b required rd=%0d d=%h ill=0",
                 i, obs_q[i].rd, obs_q[i].data, obs_q[i].ill, er[i], ed[i]);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_x0_illegal();
    logic [31:0] ed [5] = '{32'd7, 32'd0, 32'd3, 32'd0, 32'd3};
    logic        ei [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    issue(itype(12'd7, 5'd0, 3'd0, 5'd0, OPI));
    issue(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd6));
    issue(itype(12'd3, 5'd0, 3'd0, 5'd9, OPI));
    issue(itype(12'd4, 5'd0, 3'd2, 5'd9, OPL));
    issue(rtype(7'h00, 5'd0, 5'd9, 3'd0, 5'd10));
    drain();
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== ed[i] || obs_q[i].ill !== ei[i])
        $display("FAIL x0ill_%0d got d=%h ill=%b required d=%h ill=%b",
                 i, obs_q[i].data, obs_q[i].ill, ed[i], ei[i]);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    issue(itype(12'd11, 5'd0, 3'd0, 5'd20, OPI));
    issue(rtype(7'h00, 5'd20, 5'd20, 3'd0, 5'd21));
    total++;
    if (exp_q.size() != 2) $display("FAIL stall_accepted got=%0d required=2", exp_q.size());
    else passed++;
    in_valid = 1'b1;
    instruction = rtype(7'h20, 5'd21, 5'd0, 3'd0, 5'd22);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd20 ||
          out_data !== 32'd11 || out_illegal !== 1'b0)
        $display("FAIL stall_hold_%0d rdy=%b ov=%b rd=%0d d=%h ill=%b required 0/1/20/b/0",
                 c, in_ready, out_valid, out_rd, out_data, out_illegal);
      else passed++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(instruction);
    drain();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL stall_order_%0d got rd=%0d d=%h required rd=%0d d=%h",
                 i, obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(rand_instr());
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    drain();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL random_%0d got rd=%0d ill=%b d=%h required rd=%0d ill=%b d=%h",
                 i, obs_q[i].rd, obs_q[i].ill, obs_q[i].data,
                 exp_q[i].rd, exp_q[i].ill, exp_q[i].data);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_in_flight();
    out_ready = 1'b0;
    issue(itype(12'd55, 5'd0, 3'd0, 5'd11, OPI));
    issue(itype(12'd66, 5'd0, 3'd0, 5'd12, OPI));
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL flight_during ov=%b rdy=%b required 0/0", out_valid, in_ready);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flight_after ov=%b rdy=%b required 0/1", out_valid, in_ready);
    else passed++;
    @(posedge clk);
    #1;
    issue(rtype(7'h00, 5'd12, 5'd11, 3'd0, 5'd13));
    issue(rtype(7'h00, 5'd0, 5'd12, 3'd0, 5'd14));
    drain();
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== 32'd0 || obs_q[i].ill !== 1'b0)
        $display("FAIL flight_zero_%0d got d=%h ill=%b required d=0 ill=0",
                 i, obs_q[i].data, obs_q[i].ill);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_nregs16();
    logic [31:0] ins [3];
    logic [31:0] ed  [3] = '{32'd0, 32'd9, 32'd0};
    logic        ei  [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  er  [3] = '{5'd17, 5'd3, 5'd5};
    bit acc;
    bit got;
    ins[0] = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd17);
    ins[1] = itype(12'd9, 5'd0, 3'd0, 5'd3, OPI);
    ins[2] = rtype(7'h00, 5'd16, 5'd3, 3'd0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      acc = 0;
      got = 0;
      v16 = 1'b1;
      i16 = ins[i];
      for (int n = 0; n < 20 && !acc; n++) begin
        @(negedge clk);
        acc = rdy16;
        @(posedge clk);
        #1;
      end
      v16 = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = ov16;
        if (!got) begin
          @(posedge clk);
          #1;
        end
      end
      total++;
      if (!got || d16 !== ed[i] || ill16 !== ei[i] || rd16 !== er[i])
        $display("FAIL nregs16_%0d got v=%b rd=%0d d=%h ill=%b required v=1 rd=%0d d=%h ill=%b",
                 i, got, rd16, d16, ill16, er[i], ed[i], ei[i]);
      else passed++;
      @(posedge clk);
      #1;
    end
  endtask

`ifdef RV_EXEC_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) issue(itype(12'd0, 5'd0, 3'd0, 5'd1, OPL));
      else issue(itype(12'(i), 5'd0, 3'd0, 5'd1, OPI));
    end
    drain();
    total++;
    if (retired_count !== 32'd10 || hs_count != 10)
      $display("FAIL perf_count got=%0d seen=%0d required=10", retired_count, hs_count);
    else passed++;
    obs_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_x0_illegal();
    test_stall();
    test_random();
    test_reset_in_flight();
    test_nregs16();
`ifdef RV_EXEC_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
